// File: rtl/uart_txn_seq.sv
// rtl/uart_txn_seq.sv - UART request/response transaction sequencer (send ADDR_BYTES, collect RESP_BYTES).
// Optional response timeout enabled by defining UART_TXN_SEQ_TIMEOUT_EN.
module uart_txn_seq #(
  parameter int ADDR_BYTES = 2,
  parameter int RESP_BYTES = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*ADDR_BYTES-1:0] address,
  input  logic                    peer_rdy,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  input  logic                    rx_done,
  input  logic [7:0]              rx_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [8*RESP_BYTES-1:0] d_out
);
  localparam int AW  = 8 * ADDR_BYTES;
  localparam int RW  = 8 * RESP_BYTES;
  localparam int TCW = $clog2(ADDR_BYTES + 1);
  localparam int RCW = $clog2(RESP_BYTES + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, FINISH} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  shift_q, shift_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [RW-1:0]  shadow_q, shadow_d;
  logic [RW-1:0]  d_out_q, d_out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT + 1);
  logic [TMW-1:0] tmo_q, tmo_d;
  logic           err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    shadow_d = shadow_q;
    d_out_d  = d_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_en    = 1'b0;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = address;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          busy_d   = 1'b1;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = SEND;
        end
      end
      SEND: begin
        if (peer_rdy) begin
          tx_en   = 1'b1;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // tx_done has priority; a coincident rx_done is simply not looked at here
        if (tx_done) begin
          shift_d  = shift_q << 8;
          tx_cnt_d = tx_cnt_q + TCW'(1);
          if (tx_cnt_q == TCW'(ADDR_BYTES - 1)) begin
            state_d = RECV;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            state_d = SEND;
          end
        end
      end
      RECV: begin
        if (rx_done) begin
          for (int i = 0; i < RESP_BYTES; i++) begin
            if (rx_cnt_q == RCW'(i)) shadow_d[RW-8-8*i +: 8] = rx_data;
          end
          rx_cnt_d = rx_cnt_q + RCW'(1);
`ifdef UART_TXN_SEQ_TIMEOUT_EN
          tmo_d    = '0;
`endif
          if (rx_cnt_q == RCW'(RESP_BYTES - 1)) state_d = FINISH;
        end
`ifdef UART_TXN_SEQ_TIMEOUT_EN
        else if (tmo_q == TMW'(TIMEOUT - 1)) begin
          // abandon the response; d_out keeps the last complete one
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMW'(1);
        end
`endif
      end
      FINISH: begin
        d_out_d = shadow_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      shadow_q <= '0;
      d_out_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      shadow_q <= shadow_d;
      d_out_q  <= d_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign tx_data = shift_q[AW-1 -: 8];
  assign busy    = busy_q;
  assign done    = done_q;
  assign d_out   = d_out_q;
`ifdef UART_TXN_SEQ_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txn_seq.sv
// tb/tb_uart_txn_seq.sv - randomized self-checking bench for uart_txn_seq against a byte-level transaction model.
// Timeout scenario runs only when UART_TXN_SEQ_TIMEOUT_EN is defined.
module tb_uart_txn_seq;
  localparam int AB  = 2;
  localparam int RB  = 2;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst, start, peer_rdy, tx_en, tx_done, rx_done, busy, done, err;
  logic [15:0] address, d_out;
  logic [7:0]  tx_data, rx_data;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] model_dout;

  uart_txn_seq #(.ADDR_BYTES(AB), .RESP_BYTES(RB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .address(address), .peer_rdy(peer_rdy),
    .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done), .rx_done(rx_done),
    .rx_data(rx_data), .busy(busy), .done(done), .err(err), .d_out(d_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One transaction: model expects address bytes MSB-first, response packed first-byte-high.
  task automatic do_txn(input logic [15:0] addr, input logic [7:0] r0, input logic [7:0] r1,
                        input int first_gap, input int max_gap, input bit noise,
                        input bit restart, input bit tmo);
    logic [7:0] exp_tx[AB];
    logic [7:0] resp[RB];
    int t0, gap, n;
    bit got;
    exp_tx[0] = addr[15:8];
    exp_tx[1] = addr[7:0];
    resp[0] = r0;
    resp[1] = r1;
    step();
    start = 1'b1; address = addr; peer_rdy = 1'b0; t0 = cyc;
    step();
    start = 1'b0; address = 16'($urandom);
    for (int k = 0; k < AB; k++) begin
      peer_rdy = 1'b0;
      gap = (k == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        if (noise) begin rx_done = 1'b1; tx_done = 1'b1; rx_data = 8'hFF; end
        sample();
        check("tx_en_gated", tx_en, 0);
        check("busy_send", busy, 1);
        step();
        rx_done = 1'b0; tx_done = 1'b0;
      end
      peer_rdy = 1'b1;
      sample();
      check("tx_en_launch", tx_en, 1);
      check("tx_data", tx_data, exp_tx[k]);
      if (k == 0) check("err_cleared", err, 0);
      step();
      peer_rdy = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        if (noise) begin rx_done = 1'b1; rx_data = 8'hFF; end
        sample();
        check("tx_en_wait", tx_en, 0);
        check("tx_data_hold", tx_data, exp_tx[k]);
        step();
        rx_done = 1'b0;
      end
      tx_done = 1'b1;
      if (noise) begin rx_done = 1'b1; rx_data = 8'hFF; end
      step();
      tx_done = 1'b0; rx_done = 1'b0;
    end
    for (int j = 0; j < RB; j++) begin
      if (tmo && j == 1) break;
      gap = (restart && j == 0) ? int'($urandom_range(1, max_gap + 1)) : int'($urandom_range(0, max_gap));
      for (int g = 0; g < gap; g++) begin
        if (restart && g == 0) begin start = 1'b1; address = ~addr; end
        if (noise) tx_done = 1'b1;
        sample();
        check("busy_recv", busy, 1);
        check("tx_en_recv", tx_en, 0);
        step();
        start = 1'b0; tx_done = 1'b0;
      end
      rx_done = 1'b1; rx_data = resp[j];
      step();
      rx_done = 1'b0;
    end
    n = 0; got = 1'b0;
    for (int w = 0; w < TMO + 40; w++) begin
      sample();
      if (done) begin got = 1'b1; break; end
      n++;
      step();
    end
    check("done_seen", got, 1);
    if (got) begin
      if (!tmo) model_dout = {r0, r1};
      check("d_out", d_out, model_dout);
      check("err_at_done", err, tmo);
      check("busy_at_done", busy, 0);
      if (tmo) check("timeout_cycles", n, TMO);
      if (first_gap == 0 && max_gap == 0 && !tmo && !restart)
        check("latency", cyc - t0, 2 * AB + RB + 2);
      step();
      sample();
      check("done_pulse", done, 0);
      check("err_hold", err, tmo);
    end
  endtask

  task automatic reset_mid_txn();
    step();
    start = 1'b1; address = 16'hC3C3; peer_rdy = 1'b1;
    step();
    start = 1'b0;
    sample();
    check("rst_pre_tx_data", tx_data, 8'hC3);
    step();
    rst = 1'b1; tx_done = 1'b1; rx_done = 1'b1; rx_data = 8'hFF;
    step();
    rst = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
    model_dout = '0;
    sample();
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_d_out", d_out, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      check("rst_no_done", done, 0);
      check("rst_idle_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; address = '0; peer_rdy = 1'b0;
    tx_done = 1'b0; rx_done = 1'b0; rx_data = '0; model_dout = '0;
    repeat (2) step();
    rst = 1'b0;
    sample();
    check("reset_tx_en", tx_en, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_d_out", d_out, 0);

    do_txn(16'hA55A, 8'h12, 8'h34, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef UART_TXN_SEQ_TIMEOUT_EN
    do_txn(16'($urandom), 8'h77, 8'h00, 0, 0, 1'b0, 1'b0, 1'b1);
`endif
    do_txn(16'($urandom), 8'($urandom), 8'($urandom), 10, 2, 1'b0, 1'b0, 1'b0);
    do_txn(16'($urandom), 8'($urandom), 8'($urandom), -1, 3, 1'b0, 1'b1, 1'b0);
    do_txn(16'($urandom), 8'h9C, 8'h3E, -1, 3, 1'b1, 1'b0, 1'b0);
    reset_mid_txn();
    do_txn(16'h0102, 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      do_txn(16'($urandom), 8'($urandom), 8'($urandom), -1, 4,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
